// File: rtl/sdcard_cmd_line_engine.sv
// Host-side SD command-line engine: free-running SD clock, 48-bit CRC7 command
// serialiser, CMD turnaround, and response capture with timeout/CRC/end-bit checks.
module sdcard_cmd_line_engine #(
    parameter int CLK_DIV      = 2,
    parameter int RESP_TIMEOUT = 64,
    parameter int GAP_CLKS     = 8
) (
    input  logic         iCLK,
    input  logic         iRESET,
    output logic         oSD_CLK,
    inout  wire          bSD_CMD,
    output logic         oIS_CMD_OUTPUT,
    input  logic         iCMD_START,
    input  logic [5:0]   iCMD_INDEX,
    input  logic [31:0]  iCMD_ARG,
    input  logic [1:0]   iRESP_TYPE,
    output logic         oBUSY,
    output logic         oDONE,
    output logic [127:0] oRESP,
    output logic         oTIMEOUT,
    output logic         oCRC_ERR
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = $clog2(RESP_TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);

    typedef enum logic [2:0] {IDLE, SEND, TURN, RECV, GAP} stateType;

    stateType           stateReg, stateNext;
    logic [DIV_W-1:0]   divCntReg;
    logic               sdClkReg;
    logic [39:0]        txFrameReg, txFrameNext;
    logic [1:0]         respTypeReg, respTypeNext;
    logic [7:0]         bitCntReg, bitCntNext;
    logic [TO_W-1:0]    toCntReg, toCntNext;
    logic [GAP_W-1:0]   gapCntReg, gapCntNext;
    logic [6:0]         crcReg, crcNext;
    logic [126:0]       rxShiftReg, rxShiftNext;
    logic               cmdOeReg, cmdOeNext;
    logic               cmdOutReg, cmdOutNext;
    logic               doneReg, doneNext;
    logic [127:0]       respReg, respNext;
    logic               timeoutReg, timeoutNext;
    logic               crcErrReg, crcErrNext;

    logic               divTerm, riseTick, fallTick;
    logic               rxBit;
    logic [127:0]       rxShifted;
    logic               rxInCrc;
    logic [7:0]         rxLastIdx;

    function automatic logic [6:0] crc7Step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // Divider: the tick strobes fire on the cycle whose edge moves oSD_CLK.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            divCntReg <= '0;
            sdClkReg  <= 1'b0;
        end else if (divTerm) begin
            divCntReg <= '0;
            sdClkReg  <= ~sdClkReg;
        end else begin
            divCntReg <= divCntReg + 1'b1;
        end
    end

    assign divTerm  = (divCntReg == DIV_W'(CLK_DIV - 1));
    assign riseTick = divTerm & ~sdClkReg;
    assign fallTick = divTerm &  sdClkReg;

    assign rxBit     = bSD_CMD;
    assign rxShifted = {rxShiftReg, rxBit};
    // Receive index counts the start bit as 0; R2 CRC skips the 8-bit header.
    assign rxInCrc   = (respTypeReg == 2'd2) ? (bitCntReg >= 8'd8 && bitCntReg < 8'd128)
                                             : (bitCntReg < 8'd40);
    assign rxLastIdx = (respTypeReg == 2'd2) ? 8'd135 : 8'd47;

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            stateReg    <= IDLE;
            txFrameReg  <= '0;
            respTypeReg <= '0;
            bitCntReg   <= '0;
            toCntReg    <= '0;
            gapCntReg   <= '0;
            crcReg      <= '0;
            rxShiftReg  <= '0;
            cmdOeReg    <= 1'b0;
            cmdOutReg   <= 1'b1;
            doneReg     <= 1'b0;
            respReg     <= '0;
            timeoutReg  <= 1'b0;
            crcErrReg   <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            txFrameReg  <= txFrameNext;
            respTypeReg <= respTypeNext;
            bitCntReg   <= bitCntNext;
            toCntReg    <= toCntNext;
            gapCntReg   <= gapCntNext;
            crcReg      <= crcNext;
            rxShiftReg  <= rxShiftNext;
            cmdOeReg    <= cmdOeNext;
            cmdOutReg   <= cmdOutNext;
            doneReg     <= doneNext;
            respReg     <= respNext;
            timeoutReg  <= timeoutNext;
            crcErrReg   <= crcErrNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        txFrameNext  = txFrameReg;
        respTypeNext = respTypeReg;
        bitCntNext   = bitCntReg;
        toCntNext    = toCntReg;
        gapCntNext   = gapCntReg;
        crcNext      = crcReg;
        rxShiftNext  = rxShiftReg;
        cmdOeNext    = cmdOeReg;
        cmdOutNext   = cmdOutReg;
        doneNext     = 1'b0;
        respNext     = respReg;
        timeoutNext  = timeoutReg;
        crcErrNext   = crcErrReg;
        case (stateReg)
            IDLE: begin
                if (iCMD_START) begin
                    stateNext    = SEND;
                    txFrameNext  = {2'b01, iCMD_INDEX, iCMD_ARG};
                    respTypeNext = iRESP_TYPE;
                    bitCntNext   = '0;
                    crcNext      = '0;
                    timeoutNext  = 1'b0;
                    crcErrNext   = 1'b0;
                end
            end
            SEND: begin
                if (fallTick) begin
                    cmdOeNext = 1'b1;
                    if (bitCntReg < 8'd40) begin
                        cmdOutNext  = txFrameReg[39];
                        txFrameNext = {txFrameReg[38:0], 1'b0};
                        crcNext     = crc7Step(crcReg, txFrameReg[39]);
                        bitCntNext  = bitCntReg + 8'd1;
                    end else if (bitCntReg < 8'd47) begin
                        // CRC register doubles as the transmit shifter for its own bits
                        cmdOutNext = crcReg[6];
                        crcNext    = {crcReg[5:0], 1'b0};
                        bitCntNext = bitCntReg + 8'd1;
                    end else if (bitCntReg == 8'd47) begin
                        cmdOutNext = 1'b1;
                        bitCntNext = bitCntReg + 8'd1;
                    end else if (respTypeReg == 2'd0) begin
                        cmdOutNext = 1'b1;
                        gapCntNext = '0;
                        stateNext  = GAP;
                    end else begin
                        cmdOeNext = 1'b0;
                        toCntNext = '0;
                        stateNext = TURN;
                    end
                end
            end
            TURN: begin
                if (riseTick) begin
                    if (!rxBit) begin
                        stateNext   = RECV;
                        bitCntNext  = 8'd1;
                        crcNext     = '0;
                        rxShiftNext = '0;
                    end else if (toCntReg == TO_W'(RESP_TIMEOUT - 1)) begin
                        timeoutNext = 1'b1;
                        stateNext   = GAP;
                    end else begin
                        toCntNext = toCntReg + 1'b1;
                    end
                end
            end
            RECV: begin
                if (riseTick) begin
                    rxShiftNext = rxShifted[126:0];
                    bitCntNext  = bitCntReg + 8'd1;
                    if (rxInCrc)
                        crcNext = crc7Step(crcReg, rxBit);
                    if (bitCntReg == rxLastIdx) begin
                        crcErrNext = ~rxBit | ((respTypeReg != 2'd3) && (crcReg != rxShifted[7:1]));
                        respNext   = (respTypeReg == 2'd2) ? rxShifted : {88'd0, rxShifted[47:8]};
                        stateNext  = GAP;
                    end
                end
            end
            GAP: begin
                if (fallTick) begin
                    if (!cmdOeReg) begin
                        cmdOeNext  = 1'b1;
                        cmdOutNext = 1'b1;
                        gapCntNext = '0;
                    end else if (gapCntReg == GAP_W'(GAP_CLKS - 1)) begin
                        cmdOeNext = 1'b0;
                        doneNext  = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        gapCntNext = gapCntReg + 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bSD_CMD        = cmdOeReg ? cmdOutReg : 1'bz;
    assign oSD_CLK        = sdClkReg;
    assign oIS_CMD_OUTPUT = cmdOeReg;
    assign oBUSY          = (stateReg != IDLE);
    assign oDONE          = doneReg;
    assign oRESP          = respReg;
    assign oTIMEOUT       = timeoutReg;
    assign oCRC_ERR       = crcErrReg;
endmodule

// File: tb/tb_sdcard_cmd_line_engine.sv
// Scoreboard bench: stimulus pushes expected frames/results; monitors pop and compare.
module tb_sdcard_cmd_line_engine;
    localparam int CLK_DIV      = 2;
    localparam int RESP_TIMEOUT = 64;
    localparam int GAP_CLKS     = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sdClk;
    wire          sdCmd;
    logic         isCmdOutput;
    logic         cmdStart = 1'b0;
    logic [5:0]   cmdIndex = '0;
    logic [31:0]  cmdArg = '0;
    logic [1:0]   respType = '0;
    logic         busy, done;
    logic [127:0] resp;
    logic         timeoutFlag, crcErr;

    logic         cardBit = 1'b1;
    logic         cardArm = 1'b0;
    logic [135:0] cardRsp = '0;
    int           cardLen = 48;
    int           cardDelay = 0;

    typedef struct packed {
        logic [127:0] resp;
        logic         to;
        logic         ce;
    } expT;

    expT          expQ[$];
    logic [47:0]  frameQ[$];
    logic [127:0] lastResp = '0;
    int           compared = 0;
    int           mismatched = 0;
    int           doneCount = 0;

    assign sdCmd = isCmdOutput ? 1'bz : cardBit;

    sdcard_cmd_line_engine #(
        .CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TIMEOUT), .GAP_CLKS(GAP_CLKS)
    ) dut (
        .iCLK(clk), .iRESET(reset), .oSD_CLK(sdClk), .bSD_CMD(sdCmd),
        .oIS_CMD_OUTPUT(isCmdOutput), .iCMD_START(cmdStart), .iCMD_INDEX(cmdIndex),
        .iCMD_ARG(cmdArg), .iRESP_TYPE(respType), .oBUSY(busy), .oDONE(done),
        .oRESP(resp), .oTIMEOUT(timeoutFlag), .oCRC_ERR(crcErr)
    );

    always #5 clk = ~clk;

    // CRC7 as polynomial long division of msg*x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7(input logic [127:0] msg, input int n);
        logic [134:0] m;
        m = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
        return m[6:0];
    endfunction

    function automatic logic [47:0] hostFrame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7({88'd0, h}, 40), 1'b1};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Card: after the host releases CMD, wait, then shift the response out on SD falls.
    initial begin
        forever begin
            @(negedge isCmdOutput);
            if (cardArm) begin
                cardArm = 1'b0;
                for (int i = 0; i < cardDelay; i++) @(negedge sdClk);
                for (int i = 0; i < cardLen; i++) begin
                    cardBit = cardRsp[cardLen - 1 - i];
                    @(negedge sdClk);
                end
                cardBit = 1'b1;
            end
        end
    end

    // Command frame monitor: 48 bits sampled on SD rises once the host drives CMD.
    initial begin
        logic [47:0] got;
        logic [47:0] want;
        bit          ok;
        forever begin
            @(posedge busy);
            @(posedge isCmdOutput);
            got = '0;
            ok  = 1'b1;
            for (int i = 0; i < 48; i++) begin
                @(posedge sdClk);
                #1;
                got = {got[46:0], sdCmd};
                if (!busy) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (ok) begin
                if (frameQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame: got %h, expected none", got);
                end else begin
                    want = frameQ.pop_front();
                    chk("cmd_frame", {80'd0, got}, {80'd0, want});
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got oDONE, expected none");
                end else begin
                    e = expQ.pop_front();
                    chk("resp", resp, e.resp);
                    chk("timeout", {127'd0, timeoutFlag}, {127'd0, e.to});
                    chk("crc_err", {127'd0, crcErr}, {127'd0, e.ce});
                    chk("busy_at_done", {127'd0, busy}, 128'd0);
                    chk("released_at_done", {127'd0, isCmdOutput}, 128'd0);
                end
            end
        end
    end

    task automatic runCmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                          input bit respond, input int dly, input logic [135:0] rsp,
                          input logic [47:0] txFrame, input bit pokeBusy, input bit measureTurn);
        expT e;
        int  d0;
        int  n;
        int  lo;
        e.to   = (rt != 2'd0) && !respond;
        e.ce   = 1'b0;
        e.resp = lastResp;
        if (rt != 2'd0 && respond) begin
            if (rt == 2'd2) begin
                e.resp = rsp[127:0];
                e.ce   = (crc7({8'd0, rsp[127:8]}, 120) != rsp[7:1]) || !rsp[0];
            end else begin
                e.resp = {88'd0, rsp[47:8]};
                e.ce   = (rt == 2'd1 && crc7({88'd0, rsp[47:8]}, 40) != rsp[7:1]) || !rsp[0];
            end
        end
        lastResp = e.resp;
        frameQ.push_back(txFrame);
        expQ.push_back(e);
        cardRsp   = rsp;
        cardLen   = (rt == 2'd2) ? 136 : 48;
        cardDelay = dly;
        cardArm   = (rt != 2'd0) && respond;
        d0 = doneCount;
        @(negedge clk);
        cmdStart = 1'b1; cmdIndex = idx; cmdArg = arg; respType = rt;
        @(negedge clk);
        cmdStart = 1'b0;
        if (pokeBusy) begin
            repeat (30) @(negedge clk);
            cmdStart = 1'b1; cmdIndex = idx ^ 6'h15; cmdArg = ~arg; respType = 2'd1;
            @(negedge clk);
            cmdStart = 1'b0;
        end
        if (measureTurn) begin
            n = 0;
            while (!isCmdOutput && n < 2000) begin @(negedge clk); n++; end
            while (isCmdOutput && n < 2000) begin @(negedge clk); n++; end
            lo = 0;
            while (!isCmdOutput && lo < 5000) begin @(negedge clk); lo++; end
            chk("turn_cycles", 128'(lo), 128'(RESP_TIMEOUT * 2 * CLK_DIV));
        end
        n = 0;
        while (doneCount == d0 && n < 20000) begin @(negedge clk); n++; end
        if (doneCount == d0) begin
            compared++;
            mismatched++;
            $display("FAIL done_wait: no oDONE within %0d cycles", n);
        end
        $display("txn idx=%0d arg=%h type=%0d respond=%0d resp=%h timeout=%0d crcErr=%0d",
                 idx, arg, rt, respond, resp, timeoutFlag, crcErr);
    endtask

    initial begin
        #1000000;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [135:0] rsp;
        logic [127:0] pay;
        logic [39:0]  h;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rt;
        bit           respond;
        int           dly, fi, first, second, d0;
        logic         prev;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sdclk", {127'd0, sdClk}, 128'd0);
        chk("rst_oe", {127'd0, isCmdOutput}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_resp", resp, 128'd0);
        chk("rst_timeout", {127'd0, timeoutFlag}, 128'd0);
        chk("rst_crc_err", {127'd0, crcErr}, 128'd0);
        reset = 1'b0;

        prev = sdClk; first = -1; second = -1;
        for (int c = 0; c < 100 && second < 0; c++) begin
            @(negedge clk);
            if (sdClk && !prev) begin
                if (first < 0) first = c;
                else second = c;
            end
            prev = sdClk;
        end
        chk("sdclk_period", 128'(second - first), 128'(2 * CLK_DIV));

        // CMD0 with a start request injected while busy.
        runCmd(6'd0, 32'd0, 2'd0, 1'b0, 0, '0, 48'h400000000095, 1'b1, 1'b0);

        // CMD8 with a correct R7-style answer two clocks after release.
        rsp = {88'd0, 48'h08000001AA13};
        runCmd(6'd8, 32'h000001AA, 2'd1, 1'b1, 2, rsp, 48'h48000001AA87, 1'b0, 1'b0);
        chk("cmd8_resp", resp, {88'd0, 40'h08000001AA});
        chk("cmd8_crc_ok", {127'd0, crcErr}, 128'd0);

        // Same answer with one bit flipped.
        rsp[20] = ~rsp[20];
        runCmd(6'd8, 32'h000001AA, 2'd1, 1'b1, 2, rsp, 48'h48000001AA87, 1'b0, 1'b0);
        chk("cmd8_flip_crc_err", {127'd0, crcErr}, 128'd1);

        // Silent card: timeout, measured from release to re-drive.
        runCmd(6'd55, 32'h12345678, 2'd1, 1'b0, 0, '0, hostFrame(6'd55, 32'h12345678), 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("timeout_held", {127'd0, timeoutFlag}, 128'd1);

        // R2 with random payload and correct CRC.
        pay = {$urandom, $urandom, $urandom, $urandom};
        rsp = {2'b00, 6'h3f, pay[119:0], crc7({8'd0, pay[119:0]}, 120), 1'b1};
        runCmd(6'd2, 32'd0, 2'd2, 1'b1, 5, rsp, hostFrame(6'd2, 32'd0), 1'b0, 1'b0);
        chk("r2_crc_ok", {127'd0, crcErr}, 128'd0);

        // R3 with a deliberately wrong CRC field.
        h = {2'b00, 6'h3f, 32'h80FF8000};
        rsp = {88'd0, h, crc7({88'd0, h}, 40) ^ 7'h55, 1'b1};
        runCmd(6'd41, 32'h00FF8000, 2'd3, 1'b1, 3, rsp, hostFrame(6'd41, 32'h00FF8000), 1'b0, 1'b0);
        chk("r3_no_crc_check", {127'd0, crcErr}, 128'd0);

        for (int t = 0; t < 12; t++) begin
            idx = 6'($urandom); arg = $urandom; rt = 2'($urandom_range(0, 3));
            respond = ($urandom_range(0, 4) != 0);
            dly = $urandom_range(0, 20);
            if (rt == 2'd2) begin
                pay = {$urandom, $urandom, $urandom, $urandom};
                rsp = {2'b00, 6'h3f, pay[119:0], crc7({8'd0, pay[119:0]}, 120), 1'b1};
            end else begin
                h = {2'b00, 6'($urandom), 32'($urandom)};
                rsp = {88'd0, h, crc7({88'd0, h}, 40), 1'b1};
                if (rt == 2'd3 && $urandom_range(0, 1) == 1) rsp[7:1] = ~rsp[7:1];
            end
            if ($urandom_range(0, 3) == 0) begin
                fi = $urandom_range(0, (rt == 2'd2) ? 134 : 46);
                rsp[fi] = ~rsp[fi];
            end
            runCmd(idx, arg, rt, respond, dly, rsp, hostFrame(idx, arg), 1'b0, 1'b0);
        end

        // Reset in the middle of SEND aborts without a completion pulse.
        d0 = doneCount;
        @(negedge clk);
        cmdStart = 1'b1; cmdIndex = 6'd17; cmdArg = $urandom; respType = 2'd0;
        @(negedge clk);
        cmdStart = 1'b0;
        repeat (60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_oe", {127'd0, isCmdOutput}, 128'd0);
        chk("abort_done", {127'd0, done}, 128'd0);
        reset = 1'b0;
        repeat (1500) @(negedge clk);
        chk("abort_no_done", 128'(doneCount), 128'(d0));
        $display("txn reset-abort doneCount=%0d", doneCount);

        chk("frameQ_empty", 128'(frameQ.size()), 128'd0);
        chk("expQ_empty", 128'(expQ.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
